odd_even_gen: RTL and testbench

- Streaming generator of consecutive odd or even numbers; the producing counterpart of the odd/even classifier.
- Upstream logic requests a run of a given length, parity and start point.
- The block emits the sequence one value per handshake on a valid/ready output stream.
- Used to drive classifier benches and datapaths that need parity-constrained operands.

---
 rtl/odd_even_gen.sv | 108 ++++++++++
 tb/tb_odd_even_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/odd_even_gen.sv
// odd_even_gen: streams a run of consecutive odd or even values over valid/ready.
// Ports: clk, rst_n (sync, active low), start/sel_odd/start_val/count request,
//   out_ready in; out_valid/out_data stream, busy (run active), done (1-cycle pulse).
module odd_even_gen #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sel_odd,
  input  logic [N-1:0] start_val,
  input  logic [N-1:0] count,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] rem_q, rem_d;

  logic [N-1:0] first_val;
  logic         fix;

  // Bump the seed by one when its parity disagrees with the request;
  // the parity of the run is then carried by out_data itself.
  assign fix       = start_val[0] ^ sel_odd;
  assign first_val = start_val + {{(N-1){1'b0}}, fix};

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rem_d       = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d     = S_RUN;
            out_valid_d = 1'b1;
            out_data_d  = first_val;
            busy_d      = 1'b1;
            rem_d       = count;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (out_valid_q && out_ready) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(N-1){1'b0}}, 1'b1}) begin
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            out_data_d = out_data_q + {{(N-2){1'b0}}, 2'b10};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rem_q       <= rem_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_odd_even_gen.sv
// tb_odd_even_gen: randomized + directed scoreboard bench for odd_even_gen.
// Expected values come from a plain-arithmetic model pushed into a queue.
module tb_odd_even_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sel_odd;
  logic [7:0] start_val;
  logic [7:0] count;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  odd_even_gen #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sel_odd   (sel_odd),
    .start_val (start_val),
    .count     (count),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned done_seen = 0;
  int unsigned xfers = 0;
  int          exp_q[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  bit          prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: a run is just count values of the requested parity,
  // starting at the first such value >= start_val, spaced by 2 mod 256.
  task automatic model_push(input bit odd, input int sv, input int cnt);
    int first;
    first = sv;
    if ((sv % 2) != int'(odd)) first = (sv + 1) % 256;
    for (int k = 0; k < cnt; k++) exp_q.push_back((first + 2 * k) % 256);
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(prev_data));
      end
      if (out_valid) chk("busy_in_run", int'(busy), 1);
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", int'(out_data), -1);
        end else begin
          chk("out_data", int'(out_data), exp_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        chk("done_busy", int'(busy), 0);
        chk("done_valid", int'(out_valid), 0);
        if (prev_done) chk("done_width", 2, 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_done  = done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pat[6] = '{1, 0, 0, 1, 0, 1};

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return logic'($urandom_range(0, 1));
    if (mode == 2) return (cyc < 6) ? logic'(pat[cyc]) : 1'b1;
    return 1'b1;
  endfunction

  // mode: 0 ready held high, 1 random ready, 2 fixed toggle pattern.
  // inject: pulse start again mid-run; it must be ignored.
  task automatic run(input bit odd, input int sv, input int cnt,
                     input int mode, input bit inject);
    int d0;
    int n;
    d0        = done_seen;
    start     = 1'b1;
    sel_odd   = odd;
    start_val = 8'(sv);
    count     = 8'(cnt);
    out_ready = ready_for(mode, 0);
    model_push(odd, sv, cnt);
    step();
    start     = 1'b0;
    sel_odd   = ~odd;
    start_val = 8'($urandom);
    count     = 8'($urandom_range(1, 9));
    @(negedge clk);
    if (cnt == 0) begin
      chk("zero_valid", int'(out_valid), 0);
      chk("zero_done", int'(done), 1);
    end else begin
      chk("latency_valid", int'(out_valid), 1);
      chk("latency_busy", int'(busy), 1);
    end
    n = 1;
    while (done_seen == d0 && n < 300) begin
      out_ready = ready_for(mode, n);
      start     = inject && (n == 2);
      step();
      start = 1'b0;
      n++;
    end
    if (done_seen == d0) chk("done_timeout", 0, 1);
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("leftover", exp_q.size(), 0);
    chk("done_count", int'(done_seen - d0), 1);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    int x0;
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    sel_odd   = 1'b0;
    start_val = '0;
    count     = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    step();

    run(1'b0, 4, 4, 0, 1'b0);
    run(1'b1, 250, 4, 0, 1'b0);
    run(1'b0, 0, 3, 2, 1'b0);
    run(1'b0, 9, 0, 0, 1'b0);
    run(1'b1, 100, 5, 0, 1'b1);
    run(1'b0, 255, 2, 0, 1'b0);
    run(1'b1, 253, 4, 1, 1'b0);

    // Abandon a run with reset after the second transfer.
    d0        = done_seen;
    x0        = xfers;
    start     = 1'b1;
    sel_odd   = 1'b0;
    start_val = 8'd20;
    count     = 8'd6;
    out_ready = 1'b1;
    model_push(1'b0, 20, 6);
    step();
    start = 1'b0;
    n = 0;
    while (xfers < x0 + 2 && n < 50) begin
      step();
      n++;
    end
    if (xfers < x0 + 2) chk("rst_run_timeout", 0, 1);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_data", int'(out_data), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("midrst_nodone", int'(done_seen - d0), 0);
    run(1'b1, 7, 2, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 9)), int'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
